// File: rtl/unit_propagate_pkg.sv
// Shared types and constants for the DPLL unit-propagation datapath.
// Literals, clauses and formulas are packed structs so they travel as plain buses.
package unit_propagate_pkg;

    localparam int NUMBER_CLAUSES = 16;
    localparam int NUMBER_LITS    = 4;
    localparam int VAR_BITS       = 5;

    localparam int LIT_LEN_W = $clog2(NUMBER_LITS + 1);
    localparam int LIT_IDX_W = $clog2(NUMBER_LITS);
    localparam int CL_LEN_W  = $clog2(NUMBER_CLAUSES + 1);
    localparam int CL_IDX_W  = $clog2(NUMBER_CLAUSES);

    typedef struct packed {
        logic                neg;
        logic [VAR_BITS-1:0] var_id;
    } lit_t;

    typedef struct packed {
        lit_t [NUMBER_LITS-1:0] lits;
        logic [LIT_LEN_W-1:0]   len;
    } clause_t;

    typedef struct packed {
        clause_t [NUMBER_CLAUSES-1:0] clauses;
        logic [CL_LEN_W-1:0]          len;
    } formula_t;

    localparam lit_t     ZERO_LIT     = '0;
    localparam clause_t  ZERO_CLAUSE  = '0;
    localparam formula_t ZERO_FORMULA = '0;

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    function automatic lit_t complement(input lit_t l);
        lit_t c;
        c     = l;
        c.neg = ~l.neg;
        return c;
    endfunction

    // Length fields are wider than the slot count, so clamp before use.
    function automatic logic [CL_LEN_W-1:0] clamp_formula_len(input logic [CL_LEN_W-1:0] len);
        return (len > CL_LEN_W'(NUMBER_CLAUSES)) ? CL_LEN_W'(NUMBER_CLAUSES) : len;
    endfunction

    function automatic logic [LIT_LEN_W-1:0] clamp_clause_len(input logic [LIT_LEN_W-1:0] len);
        return (len > LIT_LEN_W'(NUMBER_LITS)) ? LIT_LEN_W'(NUMBER_LITS) : len;
    endfunction

endpackage

// File: rtl/unit_propagate_clause_reduce.sv
// Combinational reduction of one clause against an asserted literal:
// reports whether the clause is satisfied and the clause with the complement removed.
module clause_reduce
    import unit_propagate_pkg::*;
(
    input  clause_t clause,
    input  lit_t    lit,
    output logic    contains,
    output clause_t reduced
);

    lit_t                 comp_lit;
    logic [LIT_LEN_W-1:0] eff_len;
    logic [LIT_LEN_W-1:0] cnt;

    assign comp_lit = complement(lit);
    assign eff_len  = clamp_clause_len(clause.len);

    always_comb begin
        contains = 1'b0;
        reduced  = ZERO_CLAUSE;
        cnt      = '0;
        for (int j = 0; j < NUMBER_LITS; j++) begin
            if (LIT_LEN_W'(j) < eff_len) begin
                if (clause.lits[j] == lit) begin
                    contains = 1'b1;
                end
                // cnt never exceeds j here, so the truncated index stays in range.
                if (clause.lits[j] != comp_lit) begin
                    reduced.lits[cnt[LIT_IDX_W-1:0]] = clause.lits[j];
                    cnt = cnt + LIT_LEN_W'(1);
                end
            end
        end
        reduced.len = cnt;
    end

endmodule

// File: rtl/unit_propagate.sv
// Unit propagation stage: drops clauses satisfied by in_lit and strips its complement,
// one clause per clock, flagging conflict (empty clause) or satisfied (no clauses left).
module unit_propagate
    import unit_propagate_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     start,
    input  formula_t in_formula,
    input  lit_t     in_lit,
    output logic     busy,
    output logic     done,
    output formula_t out_formula,
    output logic     conflict,
    output logic     satisfied
);

    state_t              state_q, state_d;
    formula_t            f_q;
    lit_t                lit_q;
    logic [CL_LEN_W-1:0] r_q, w_q, lim;
    logic                accept;
    logic                red_contains;
    logic                red_empty;
    clause_t             cur_clause, red_clause;

    // No new request is taken in the done cycle, even though the FSM is already IDLE.
    assign accept     = (state_q == IDLE) && start && !done;
    assign lim        = clamp_formula_len(f_q.len);
    assign cur_clause = f_q.clauses[r_q[CL_IDX_W-1:0]];
    assign red_empty  = !red_contains && (red_clause.len == '0);

    clause_reduce u_reduce (
        .clause   (cur_clause),
        .lit      (lit_q),
        .contains (red_contains),
        .reduced  (red_clause)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (clamp_formula_len(in_formula.len) == '0) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                if (red_empty || (r_q + CL_LEN_W'(1) == lim)) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_q         <= ZERO_FORMULA;
            lit_q       <= ZERO_LIT;
            r_q         <= '0;
            w_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_formula <= ZERO_FORMULA;
            conflict    <= 1'b0;
            satisfied   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        f_q         <= in_formula;
                        lit_q       <= in_lit;
                        r_q         <= '0;
                        w_q         <= '0;
                        out_formula <= ZERO_FORMULA;
                        conflict    <= 1'b0;
                        satisfied   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SCAN: begin
                    r_q <= r_q + CL_LEN_W'(1);
                    if (red_empty) begin
                        conflict <= 1'b1;
                    end else if (!red_contains) begin
                        out_formula.clauses[w_q[CL_IDX_W-1:0]] <= red_clause;
                        w_q <= w_q + CL_LEN_W'(1);
                    end
                end
                FINISH: begin
                    out_formula.len <= w_q;
                    satisfied       <= (w_q == '0) && !conflict;
                    done            <= 1'b1;
                    busy            <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Variable 0 is reserved; asserting it as a literal is a caller error.
    a_lit_nonzero: assert property (@(posedge clock) disable iff (reset)
        accept |-> (in_lit.var_id != '0));

endmodule

// File: tb/tb_unit_propagate.sv
// Directed self-checking bench for unit_propagate: hand-built formulas with
// hand-computed simplified results, latencies and flag values.
module tb_unit_propagate;
    import unit_propagate_pkg::*;

    logic     clock;
    logic     reset;
    logic     start;
    formula_t in_formula;
    lit_t     in_lit;
    logic     busy;
    logic     done;
    formula_t out_formula;
    logic     conflict;
    logic     satisfied;

    int tests;
    int fails;

    unit_propagate dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_formula  (in_formula),
        .in_lit      (in_lit),
        .busy        (busy),
        .done        (done),
        .out_formula (out_formula),
        .conflict    (conflict),
        .satisfied   (satisfied)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_form(input string tag, input formula_t obs, input formula_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic lit_t lp(input int v);
        lit_t l;
        l.neg    = 1'b0;
        l.var_id = VAR_BITS'(v);
        return l;
    endfunction

    function automatic lit_t ln(input int v);
        lit_t l;
        l.neg    = 1'b1;
        l.var_id = VAR_BITS'(v);
        return l;
    endfunction

    function automatic clause_t mk_cl(input lit_t a, input lit_t b, input lit_t c,
                                      input lit_t d, input int n);
        clause_t cl;
        cl.lits[0] = a;
        cl.lits[1] = b;
        cl.lits[2] = c;
        cl.lits[3] = d;
        cl.len     = LIT_LEN_W'(n);
        return cl;
    endfunction

    // Pulse (or hold) start, then count edges after the accepting edge until done.
    task automatic run(input formula_t f, input lit_t l, input bit hold, output int edges);
        in_formula = f;
        in_lit     = l;
        start      = 1'b1;
        tick();
        check_bit("busy_after_accept", busy, 1'b1);
        if (!hold) start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check_bit("busy_low_at_done", busy, 1'b0);
    endtask

    task automatic after_done(input string tag);
        tick();
        check_bit({tag, "_done_one_cycle"}, done, 1'b0);
        check_bit({tag, "_idle_after"}, busy, 1'b0);
    endtask

    formula_t f, exp_f;
    int       edges;
    lit_t     z;

    initial begin
        tests      = 0;
        fails      = 0;
        z          = ZERO_LIT;
        reset      = 1'b1;
        start      = 1'b0;
        in_formula = ZERO_FORMULA;
        in_lit     = lp(1);
        #12;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_conflict", conflict, 1'b0);
        check_bit("rst_satisfied", satisfied, 1'b0);
        check_form("rst_out", out_formula, ZERO_FORMULA);
        reset = 1'b0;
        tick();

        // Basic: (x1|~x2),(x2),(~x1|x3) with x2 -> (x1),(~x1|x3)
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(lp(1), ln(2), z, z, 2);
        f.clauses[1] = mk_cl(lp(2), z, z, z, 1);
        f.clauses[2] = mk_cl(ln(1), lp(3), z, z, 2);
        f.len = 3;
        run(f, lp(2), 1'b0, edges);
        exp_f = ZERO_FORMULA;
        exp_f.clauses[0] = mk_cl(lp(1), z, z, z, 1);
        exp_f.clauses[1] = mk_cl(ln(1), lp(3), z, z, 2);
        exp_f.len = 2;
        check_int("basic_latency", edges, 4);
        check_form("basic_out", out_formula, exp_f);
        check_bit("basic_conflict", conflict, 1'b0);
        check_bit("basic_satisfied", satisfied, 1'b0);
        after_done("basic");
        check_form("basic_out_held", out_formula, exp_f);

        // Conflict early exit: (x3),(~x1),(x2|x4) with x1
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(lp(3), z, z, z, 1);
        f.clauses[1] = mk_cl(ln(1), z, z, z, 1);
        f.clauses[2] = mk_cl(lp(2), lp(4), z, z, 2);
        f.len = 3;
        run(f, lp(1), 1'b0, edges);
        exp_f = ZERO_FORMULA;
        exp_f.clauses[0] = mk_cl(lp(3), z, z, z, 1);
        exp_f.len = 1;
        check_int("conf_latency", edges, 3);
        check_form("conf_out", out_formula, exp_f);
        check_bit("conf_conflict", conflict, 1'b1);
        check_bit("conf_satisfied", satisfied, 1'b0);
        after_done("conf");

        // All clauses satisfied: (x1|x2),(x1) with x1
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(lp(1), lp(2), z, z, 2);
        f.clauses[1] = mk_cl(lp(1), z, z, z, 1);
        f.len = 2;
        run(f, lp(1), 1'b0, edges);
        check_int("sat_latency", edges, 3);
        check_form("sat_out", out_formula, ZERO_FORMULA);
        check_bit("sat_conflict", conflict, 1'b0);
        check_bit("sat_satisfied", satisfied, 1'b1);
        after_done("sat");

        // Empty formula
        run(ZERO_FORMULA, lp(4), 1'b0, edges);
        check_int("empty_latency", edges, 1);
        check_bit("empty_satisfied", satisfied, 1'b1);
        check_bit("empty_conflict", conflict, 1'b0);
        after_done("empty");

        // Full formula: 16 x (x5|~x1) with x1 -> 16 x (x5)
        f = ZERO_FORMULA;
        exp_f = ZERO_FORMULA;
        for (int i = 0; i < NUMBER_CLAUSES; i++) begin
            f.clauses[i]     = mk_cl(lp(5), ln(1), z, z, 2);
            exp_f.clauses[i] = mk_cl(lp(5), z, z, z, 1);
        end
        f.len = 16;
        exp_f.len = 16;
        run(f, lp(1), 1'b0, edges);
        check_int("full_latency", edges, 17);
        check_form("full_out", out_formula, exp_f);
        check_bit("full_satisfied", satisfied, 1'b0);
        after_done("full");

        // Input clause of length 0 that is not satisfied yields conflict
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(lp(7), z, z, z, 1);
        f.clauses[1] = mk_cl(z, z, z, z, 0);
        f.len = 2;
        run(f, lp(9), 1'b0, edges);
        exp_f = ZERO_FORMULA;
        exp_f.clauses[0] = mk_cl(lp(7), z, z, z, 1);
        exp_f.len = 1;
        check_int("len0cl_latency", edges, 3);
        check_form("len0cl_out", out_formula, exp_f);
        check_bit("len0cl_conflict", conflict, 1'b1);
        after_done("len0cl");

        // Start held high through the run and the done cycle: no re-trigger
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(lp(1), ln(2), z, z, 2);
        f.clauses[1] = mk_cl(lp(2), z, z, z, 1);
        f.clauses[2] = mk_cl(ln(1), lp(3), z, z, 2);
        f.len = 3;
        run(f, ln(1), 1'b1, edges);
        exp_f = ZERO_FORMULA;
        exp_f.clauses[0] = mk_cl(ln(2), z, z, z, 1);
        exp_f.clauses[1] = mk_cl(lp(2), z, z, z, 1);
        exp_f.len = 2;
        check_int("hold_latency", edges, 4);
        check_form("hold_out", out_formula, exp_f);
        tick();
        start = 1'b0;
        check_bit("hold_no_retrigger", busy, 1'b0);
        check_bit("hold_single_done", done, 1'b0);

        // Second start one cycle after done, with duplicates, both-polarity and stale slots
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(ln(3), lp(4), ln(3), lp(5), 4);
        f.clauses[1] = mk_cl(lp(3), ln(3), z, z, 2);
        f.clauses[2] = mk_cl(lp(6), lp(3), z, z, 1);
        f.len = 3;
        run(f, lp(3), 1'b0, edges);
        exp_f = ZERO_FORMULA;
        exp_f.clauses[0] = mk_cl(lp(4), lp(5), z, z, 2);
        exp_f.clauses[1] = mk_cl(lp(6), z, z, z, 1);
        exp_f.len = 2;
        check_int("second_latency", edges, 4);
        check_form("second_out", out_formula, exp_f);
        check_bit("second_conflict", conflict, 1'b0);
        after_done("second");

        // Reset during SCAN of a 5-clause run
        f = ZERO_FORMULA;
        for (int i = 0; i < 5; i++) f.clauses[i] = mk_cl(lp(i + 1), z, z, z, 1);
        f.len = 5;
        in_formula = f;
        in_lit     = lp(9);
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_bit("mid_busy_before_reset", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_bit("abort_conflict", conflict, 1'b0);
        check_bit("abort_satisfied", satisfied, 1'b0);
        check_form("abort_out", out_formula, ZERO_FORMULA);
        tick();
        check_bit("abort_no_done", done, 1'b0);
        reset = 1'b0;
        tick();

        // Normal run after the abort
        f = ZERO_FORMULA;
        f.clauses[0] = mk_cl(lp(1), ln(2), z, z, 2);
        f.clauses[1] = mk_cl(lp(2), z, z, z, 1);
        f.clauses[2] = mk_cl(ln(1), lp(3), z, z, 2);
        f.len = 3;
        run(f, lp(2), 1'b0, edges);
        exp_f = ZERO_FORMULA;
        exp_f.clauses[0] = mk_cl(lp(1), z, z, z, 1);
        exp_f.clauses[1] = mk_cl(ln(1), lp(3), z, z, 2);
        exp_f.len = 2;
        check_int("post_reset_latency", edges, 4);
        check_form("post_reset_out", out_formula, exp_f);
        after_done("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
